// File: rtl/prog_loader.sv
// Converts an ASCII program stream into 3-bit opcodes written to program memory, with bracket and size checks.
// Optional build macro PROG_LOADER_COMMENT_EN: '#' opens a comment that runs until LF.
module prog_loader #(
  parameter int DEPTH    = 256,
  parameter int MAX_NEST = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [2:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err_bracket,
  output logic       err_overflow,
  output logic [8:0] len
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t     state, state_nxt;
  logic [8:0] cnt, cnt_nxt;
  logic [7:0] nest, nest_nxt;
  logic       wr_en_nxt;
  logic [7:0] wr_addr_nxt;
  logic [2:0] wr_data_nxt;
  logic       done_nxt, err_b_nxt, err_o_nxt;
  logic [8:0] len_nxt;
`ifdef PROG_LOADER_COMMENT_EN
  logic       cmt, cmt_nxt;
`endif

  logic       is_op, is_term;
  logic [2:0] op;

  always_comb begin
    is_op = 1'b1;
    op    = 3'b000;
    case (in_data)
      8'h2B:   op = 3'b111;
      8'h2D:   op = 3'b110;
      8'h3E:   op = 3'b101;
      8'h3C:   op = 3'b100;
      8'h5B:   op = 3'b011;
      8'h5D:   op = 3'b010;
      8'h2E:   op = 3'b001;
      8'h2C:   op = 3'b000;
      default: is_op = 1'b0;
    endcase
  end

  assign is_term  = (in_data == 8'h00) || (in_data == 8'h21);
  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    nest_nxt    = nest;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    done_nxt    = done;
    err_b_nxt   = err_bracket;
    err_o_nxt   = err_overflow;
    len_nxt     = len;
`ifdef PROG_LOADER_COMMENT_EN
    cmt_nxt     = cmt;
`endif
    case (state)
      LOAD: begin
        if (in_valid) begin
          // Terminators end the load even inside a comment.
          if (is_term) begin
            if (nest == 8'd0) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
              len_nxt   = cnt;
            end else begin
              state_nxt = ERR;
              err_b_nxt = 1'b1;
            end
          end
`ifdef PROG_LOADER_COMMENT_EN
          else if (cmt) begin
            if (in_data == 8'h0A) cmt_nxt = 1'b0;
          end else if (in_data == 8'h23) begin
            cmt_nxt = 1'b1;
          end
`endif
          else if (is_op) begin
            if (cnt == 9'(DEPTH)) begin
              state_nxt = ERR;
              err_o_nxt = 1'b1;
            end else if ((op == 3'b011 && nest == 8'(MAX_NEST)) ||
                         (op == 3'b010 && nest == 8'd0)) begin
              state_nxt = ERR;
              err_b_nxt = 1'b1;
            end else begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = cnt[7:0];
              wr_data_nxt = op;
              cnt_nxt     = cnt + 9'd1;
              if (op == 3'b011) nest_nxt = nest + 8'd1;
              if (op == 3'b010) nest_nxt = nest - 8'd1;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = 9'd0;
          nest_nxt  = 8'd0;
          done_nxt  = 1'b0;
          err_b_nxt = 1'b0;
          err_o_nxt = 1'b0;
          len_nxt   = 9'd0;
`ifdef PROG_LOADER_COMMENT_EN
          cmt_nxt   = 1'b0;
`endif
        end
      end
    endcase
  end

  // Reset also drops any write decided in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 9'd0;
      nest         <= 8'd0;
      wr_en        <= 1'b0;
      wr_addr      <= 8'd0;
      wr_data      <= 3'd0;
      done         <= 1'b0;
      err_bracket  <= 1'b0;
      err_overflow <= 1'b0;
      len          <= 9'd0;
`ifdef PROG_LOADER_COMMENT_EN
      cmt          <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      nest         <= nest_nxt;
      wr_en        <= wr_en_nxt;
      wr_addr      <= wr_addr_nxt;
      wr_data      <= wr_data_nxt;
      done         <= done_nxt;
      err_bracket  <= err_b_nxt;
      err_overflow <= err_o_nxt;
      len          <= len_nxt;
`ifdef PROG_LOADER_COMMENT_EN
      cmt          <= cmt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default instance plus a DEPTH=4 instance for overflow.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, wr_en, busy, done, err_bracket, err_overflow;
  logic [7:0] wr_addr;
  logic [2:0] wr_data;
  logic [8:0] len;

  logic       start4 = 1'b0, in_valid4 = 1'b0;
  logic [7:0] in_data4 = 8'h00;
  logic       in_ready4, wr_en4, busy4, done4, err_bracket4, err_overflow4;
  logic [7:0] wr_addr4;
  logic [2:0] wr_data4;
  logic [8:0] len4;

  int checks = 0;
  int fails  = 0;
  logic [7:0] wa[$], wa4[$];
  logic [2:0] wd[$], wd4[$];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_bracket(err_bracket), .err_overflow(err_overflow),
    .len(len)
  );

  prog_loader #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4), .err_bracket(err_bracket4), .err_overflow(err_overflow4),
    .len(len4)
  );

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin wa.push_back(wr_addr); wd.push_back(wr_data); end
    if (wr_en4 === 1'b1) begin wa4.push_back(wr_addr4); wd4.push_back(wr_data4); end
  end

  task automatic do_start();
    wa.delete(); wd.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err_bracket, err_overflow, len} !== 25'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want all zero",
               {in_ready, wr_en, wr_addr, wr_data, busy, done, err_bracket, err_overflow, len});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ops();
    do_start();
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      fails++; $display("FAIL load_busy: got %b want 11", {busy, in_ready});
    end
    send_str("+-><[].,!");
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 8) begin
      fails++; $display("FAIL ops_count: got %0d want 8", wa.size());
    end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== 8'(i) || wd[i] !== 3'(7 - i)) begin
        fails++;
        $display("FAIL ops_write%0d: got addr %0d data %b want addr %0d data %b", i, wa[i], wd[i], i, 3'(7 - i));
      end
    end
    checks++;
    if ({done, err_bracket, err_overflow, busy, len} !== {4'b1000, 9'd8}) begin
      fails++; $display("FAIL ops_done: got done %b errb %b erro %b busy %b len %0d want 1 0 0 0 8",
                        done, err_bracket, err_overflow, busy, len);
    end
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b0, 8'd7, 3'b000}) begin
      fails++; $display("FAIL ops_hold_addr: got en %b addr %0d data %b want 0 7 000", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_unmatched_close();
    do_start();
    send_str("]!");
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() != 0) begin
      fails++; $display("FAIL close_nowrite: got %0d writes want 0", wa.size());
    end
    checks++;
    if ({err_bracket, done, in_ready, len} !== {3'b100, 9'd0}) begin
      fails++; $display("FAIL close_err: got errb %b done %b rdy %b len %0d want 1 0 0 0",
                        err_bracket, done, in_ready, len);
    end
  endtask

  task automatic test_unclosed();
    do_start();
    send_str("[[+]");
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (wa.size() != 4) begin
      fails++; $display("FAIL open_writes: got %0d want 4", wa.size());
    end
    checks++;
    if ({err_bracket, done, err_overflow} !== 3'b100) begin
      fails++; $display("FAIL open_err: got errb %b done %b erro %b want 1 0 0", err_bracket, done, err_overflow);
    end
  endtask

  task automatic test_overflow();
    wa4.delete(); wd4.delete();
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid4 = 1'b1; in_data4 = 8'h2B;
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    checks++;
    if ({err_overflow4, busy4} !== 2'b10) begin
      fails++; $display("FAIL ovf_flag: got erro %b busy %b want 1 0", err_overflow4, busy4);
    end
    in_valid4 = 1'b1; in_data4 = 8'h21;
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wa4.size() != 4) begin
      fails++; $display("FAIL ovf_writes: got %0d want 4", wa4.size());
    end
    for (int i = 0; i < 4 && i < wa4.size(); i++) begin
      checks++;
      if (wa4[i] !== 8'(i) || wd4[i] !== 3'b111) begin
        fails++; $display("FAIL ovf_write%0d: got addr %0d data %b want %0d 111", i, wa4[i], wd4[i], i);
      end
    end
    checks++;
    if ({err_overflow4, err_bracket4, done4, len4} !== {3'b100, 9'd0}) begin
      fails++; $display("FAIL ovf_hold: got erro %b errb %b done %b len %0d want 1 0 0 0",
                        err_overflow4, err_bracket4, done4, len4);
    end
  endtask

  task automatic test_comment();
    logic [2:0] exp_d[$];
`ifdef PROG_LOADER_COMMENT_EN
    exp_d = '{3'b111, 3'b110, 3'b001};
`else
    exp_d = '{3'b111, 3'b110, 3'b111, 3'b001};
`endif
    do_start();
    send_str("+a-#+\n.!");
    repeat (2) @(negedge clk);
    checks++;
    if (wa.size() != exp_d.size() || len !== 9'(exp_d.size()) || done !== 1'b1) begin
      fails++; $display("FAIL comment_len: got writes %0d len %0d done %b want %0d", wa.size(), len, done, exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wd.size(); i++) begin
      checks++;
      if (wd[i] !== exp_d[i] || wa[i] !== 8'(i)) begin
        fails++; $display("FAIL comment_op%0d: got addr %0d data %b want %0d %b", i, wa[i], wd[i], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back_rst();
    do_start();
    in_valid = 1'b1; in_data = 8'h2B;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err_bracket, err_overflow, len} !== 25'd0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %b want all zero",
               {in_ready, wr_en, wr_addr, wr_data, busy, done, err_bracket, err_overflow, len});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wa.size() != 2) begin
      fails++; $display("FAIL rst_mid_writes: got %0d want 2", wa.size());
    end
    do_start();
    send_str("!");
    @(negedge clk);
    checks++;
    if ({done, err_bracket, len} !== {2'b10, 9'd0} || wa.size() != 0) begin
      fails++; $display("FAIL rst_restart: got done %b errb %b len %0d writes %0d want 1 0 0 0",
                        done, err_bracket, len, wa.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_unmatched_close();
    test_unclosed();
    test_overflow();
    test_comment();
    test_back_to_back_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL provide parameter DEPTH, default 256, the program memory size in opcodes (max 256).
REQ-002 SHALL provide parameter MAX_NEST, default 255, the maximum '[' nesting depth (max 255).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port in_valid  input  1  source byte valid.
REQ-007 SHALL have port in_data  input  8  ASCII source byte.
REQ-008 SHALL have port in_ready  output  1  byte accepted this cycle when in_valid&in_ready.
REQ-009 SHALL have port wr_en  output  1  program-memory write strobe.
REQ-010 SHALL have port wr_addr  output  8  program-memory write address.
REQ-011 SHALL have port wr_data  output  3  opcode to write.
REQ-012 SHALL have ports busy, done, err_bracket, err_overflow  output  1 each  status.
REQ-013 SHALL have port len  output  9  number of opcodes written, 0..256.

Function
REQ-014 SHALL encode '+'=111, '-'=110, '>'=101, '<'=100, '['=011, ']'=010, '.'=001, ','=000.
REQ-015 SHALL implement states IDLE, LOAD, DONE, ERR; in_ready=1 only in LOAD; busy=1 only in LOAD.
REQ-016 SHALL go from IDLE, DONE or ERR to LOAD on start, clearing the write count, nest depth, done, err_bracket, err_overflow and len.
REQ-017 SHALL ignore start while in LOAD.
REQ-018 SHALL, for an accepted opcode character, assert wr_en for exactly one cycle on the following cycle, with wr_addr equal to the pre-increment count and the encoded wr_data, then increment the count.
REQ-019 SHALL consume non-opcode bytes other than the terminators without writing.
REQ-020 SHALL treat 0x00 and '!' (0x21) as terminators: at nest depth 0 go to DONE with done=1 and len=count; otherwise go to ERR with err_bracket=1.
REQ-021 SHALL increment the nest depth on '['; a '[' at depth MAX_NEST SHALL go to ERR with err_bracket=1 and SHALL NOT be written.
REQ-022 SHALL decrement the nest depth on ']'; a ']' at depth 0 SHALL go to ERR with err_bracket=1 and SHALL NOT be written.
REQ-023 SHALL, for an opcode byte arriving when count==DEPTH, go to ERR with err_overflow=1 and SHALL NOT write it.
REQ-024 SHALL hold done, err_* and len stable in DONE and ERR until the next start or rst.
REQ-025 SHALL leave wr_addr and wr_data unchanged when wr_en=0.
REQ-026 SHALL sustain one byte per cycle while in_valid is held high.

Reset
REQ-027 SHALL, on rst, force state IDLE with count=0, depth=0, and all outputs 0 (in_ready, wr_en, wr_addr, wr_data, busy, done, err_bracket, err_overflow, len).
REQ-028 SHALL give rst priority over start and over any handshake in the same cycle.
REQ-029 SHALL suppress on the next cycle any write pending from the cycle in which rst is asserted mid-load.

Configuration
REQ-030 SHALL, with PROG_LOADER_COMMENT_EN defined, treat '#' as the start of a comment in which all bytes except terminators are consumed without writing until LF (0x0A).
REQ-031 SHALL, with PROG_LOADER_COMMENT_EN defined, end the load normally (REQ-020) when a terminator arrives inside a comment.
REQ-032 SHALL, without PROG_LOADER_COMMENT_EN, treat '#' as an ordinary ignored byte and encode opcode characters that follow it.

Verification
REQ-033 SHALL cover: start, "+-><[].,!" -> wr_data 111,110,101,100,011,010,001,000 at addr 0..7; done=1, len=8.
REQ-034 SHALL cover: start, "]!" -> no write, err_bracket=1, len=0, in_ready=0.
REQ-035 SHALL cover: start, "[[+]" then 0x00 -> 4 writes, err_bracket=1, done=0.
REQ-036 SHALL cover: DEPTH=4, start, "+++++!" -> writes at addr 0..3, err_overflow=1 on the 5th '+'.
REQ-037 SHALL cover: start, "+a-#+\n.!" -> with the macro, opcodes 111,110,001 and len=3; without it, 111,110,111,001 and len=4.
REQ-038 SHALL cover: rst asserted after 2 of "+++" are accepted -> the third write is suppressed, all outputs 0, state IDLE; start then "!" -> done=1, len=0.
